// File: rtl/s298_resp_misr.sv
// Response MISR for the s298 BIST harness: folds the six s298 outputs per valid beat and
// checks the final signature against golden. Optional X-masking via S298_MISR_XMASK_EN.
module s298_resp_misr #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h1021),
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter logic [15:0]      NPAT  = 16'd100
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    input  logic             in_valid,
    input  logic [5:0]       resp,
    input  logic [WIDTH-1:0] golden,
`ifdef S298_MISR_XMASK_EN
    input  logic [5:0]       xmask,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [15:0]      pat_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StCmp, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic [5:0]       resp_eff;
    logic [WIDTH-1:0] sig_step;

`ifdef S298_MISR_XMASK_EN
    assign resp_eff = resp & ~xmask;
`else
    assign resp_eff = resp;
`endif

    // Galois MISR: shift left, fold the MSB back through POLY, then absorb the response.
    assign sig_step = {sig_q[WIDTH-2:0], 1'b0}
                    ^ (sig_q[WIDTH-1] ? POLY : '0)
                    ^ {{(WIDTH-6){1'b0}}, resp_eff};

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (in_valid) begin
                    sig_d = sig_step;
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == NPAT - 16'd1) begin
                        state_d = StCmp;
                    end
                end
            end
            StCmp: begin
                pass_d  = (sig_q == golden);
                state_d = StDone;
            end
            StDone: begin
                if (start) begin
                    pass_d  = 1'b0;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= StIdle;
            sig_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q == StRun) || (state_q == StCmp);
    assign done      = (state_q == StDone);
    assign pass      = pass_q;
    assign signature = sig_q;
    assign pat_cnt   = cnt_q;

endmodule

// File: tb/tb_s298_resp_misr.sv
// Self-checking bench for s298_resp_misr: four instances with different SEED/NPAT share
// the stimulus; a behavioural MISR model supplies expected signatures.
module tb_s298_resp_misr;

    localparam logic [3:0][15:0] SEEDS = {16'hACE1, 16'h0000, 16'h8000, 16'h0000};
    localparam logic [3:0][15:0] NPATS = {16'd100, 16'd2, 16'd1, 16'd1};

    logic        CK = 1'b0;
    logic        RN = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  resp = '0;
    logic [5:0]  xmask = '0;
    logic [15:0] golden = '0;
    logic [3:0]  busy, done, pass;
    logic [15:0] sig [4];
    logic [15:0] cnt [4];
    int          n_pass = 0;
    int          n_total = 0;

    always #5 CK = ~CK;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        s298_resp_misr #(
            .WIDTH(16),
            .POLY (16'h1021),
            .SEED (SEEDS[i]),
            .NPAT (NPATS[i])
        ) u_dut (
`ifdef S298_MISR_XMASK_EN
            .xmask    (xmask),
`endif
            .CK       (CK),
            .RN       (RN),
            .start    (start),
            .in_valid (in_valid),
            .resp     (resp),
            .golden   (golden),
            .busy     (busy[i]),
            .done     (done[i]),
            .pass     (pass[i]),
            .signature(sig[i]),
            .pat_cnt  (cnt[i])
        );
    end

    // Signature as polynomial arithmetic: multiply by x, reduce modulo x^16 + POLY, add response.
    function automatic logic [15:0] model_step(input logic [15:0] s, input logic [5:0] r);
        int unsigned v;
        v = 32'(s) * 2;
        if (v >= 32'd65536) v = (v - 32'd65536) ^ 32'h1021;
        v = v ^ 32'(r);
        return v[15:0];
    endfunction

    task automatic fresh();
        RN = 1'b0;
        @(negedge CK);
        RN = 1'b1;
        @(negedge CK);
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
    endtask

    task automatic drive_beat(input logic [5:0] r);
        in_valid = 1'b1;
        resp     = r;
        @(negedge CK);
        in_valid = 1'b0;
        resp     = 6'($urandom);
    endtask

    task automatic test_reset();
        RN = 1'b0;
        repeat (4) begin
            start    = 1'($urandom);
            in_valid = 1'($urandom);
            resp     = 6'($urandom);
            @(negedge CK);
        end
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if ({busy[i], done[i], pass[i], sig[i], cnt[i]} !== 35'd0) begin
                $display("FAIL reset_outputs dut%0d: busy=%b done=%b pass=%b sig=%h cnt=%0d, want all 0",
                         i, busy[i], done[i], pass[i], sig[i], cnt[i]);
            end else n_pass++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        RN       = 1'b1;
        @(negedge CK);
        // start with a simultaneous beat: the beat must be dropped
        start    = 1'b1;
        in_valid = 1'b1;
        resp     = 6'h3F;
        @(negedge CK);
        start    = 1'b0;
        in_valid = 1'b0;
        n_total++;
        if (busy[1] !== 1'b1 || sig[1] !== 16'h8000 || cnt[1] !== 16'd0) begin
            $display("FAIL start_seed_b: busy=%b sig=%h cnt=%0d, want 1 8000 0", busy[1], sig[1], cnt[1]);
        end else n_pass++;
        n_total++;
        if (sig[3] !== 16'hACE1 || cnt[3] !== 16'd0) begin
            $display("FAIL start_seed_d: sig=%h cnt=%0d, want ace1 0", sig[3], cnt[3]);
        end else n_pass++;
    endtask

    task automatic test_single_beat();
        fresh();
        golden = 16'h0001;
        drive_beat(6'h01);
        n_total++;
        if (sig[0] !== 16'h0001 || done[0] !== 1'b0) begin
            $display("FAIL single_sig: sig=%h done=%b, want 0001 0", sig[0], done[0]);
        end else n_pass++;
        @(negedge CK);
        n_total++;
        if (done[0] !== 1'b1 || pass[0] !== 1'b1 || busy[0] !== 1'b0) begin
            $display("FAIL single_result: done=%b pass=%b busy=%b, want 1 1 0", done[0], pass[0], busy[0]);
        end else n_pass++;
    endtask

    task automatic test_feedback();
        fresh();
        golden = 16'h0000;
        drive_beat(6'h00);
        n_total++;
        if (sig[1] !== 16'h1021) begin
            $display("FAIL feedback_sig: sig=%h, want 1021", sig[1]);
        end else n_pass++;
        @(negedge CK);
        n_total++;
        if (done[1] !== 1'b1 || pass[1] !== 1'b0 || sig[1] !== 16'h1021) begin
            $display("FAIL feedback_result: done=%b pass=%b sig=%h, want 1 0 1021", done[1], pass[1], sig[1]);
        end else n_pass++;
    endtask

    task automatic test_gaps();
        fresh();
        drive_beat(6'h01);
        n_total++;
        if (sig[2] !== 16'h0001 || cnt[2] !== 16'd1) begin
            $display("FAIL gaps_beat1: sig=%h cnt=%0d, want 0001 1", sig[2], cnt[2]);
        end else n_pass++;
        @(negedge CK);
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        @(negedge CK);
        n_total++;
        if (sig[2] !== 16'h0001 || cnt[2] !== 16'd1 || busy[2] !== 1'b1) begin
            $display("FAIL gaps_hold: sig=%h cnt=%0d busy=%b, want 0001 1 1", sig[2], cnt[2], busy[2]);
        end else n_pass++;
        drive_beat(6'h00);
        n_total++;
        if (sig[2] !== 16'h0002 || cnt[2] !== 16'd2 || done[2] !== 1'b0) begin
            $display("FAIL gaps_beat2: sig=%h cnt=%0d done=%b, want 0002 2 0", sig[2], cnt[2], done[2]);
        end else n_pass++;
        @(negedge CK);
        n_total++;
        if (done[2] !== 1'b1) begin
            $display("FAIL gaps_done: done=%b, want 1", done[2]);
        end else n_pass++;
    endtask

    task automatic test_abort();
        logic [15:0] model;
        logic [5:0]  r;
        fresh();
        model = 16'hACE1;
        for (int b = 0; b < 50; b++) begin
            r = 6'($urandom);
            model = model_step(model, r);
            drive_beat(r);
            repeat ($urandom_range(0, 2)) @(negedge CK);
        end
        n_total++;
        if (sig[3] !== model || cnt[3] !== 16'd50 || busy[3] !== 1'b1) begin
            $display("FAIL abort_midway: sig=%h cnt=%0d busy=%b, want %h 50 1", sig[3], cnt[3], busy[3], model);
        end else n_pass++;
        #2 RN = 1'b0;
        #1;
        n_total++;
        if ({busy[3], done[3], pass[3], sig[3], cnt[3]} !== 35'd0) begin
            $display("FAIL abort_reset: busy=%b done=%b pass=%b sig=%h cnt=%0d, want all 0",
                     busy[3], done[3], pass[3], sig[3], cnt[3]);
        end else n_pass++;
        @(negedge CK);
        RN = 1'b1;
        @(negedge CK);
    endtask

    task automatic run_session(input logic flip, output logic [15:0] model);
        logic [5:0] r;
        model = 16'hACE1;
        for (int b = 0; b < 100; b++) begin
            r = 6'($urandom);
            model = model_step(model, r);
            drive_beat(r);
            if (b != 99) repeat ($urandom_range(0, 2)) @(negedge CK);
        end
        golden = model ^ {15'd0, flip};
    endtask

    task automatic test_random_session();
        logic [15:0] model;
        fresh();
        run_session(1'b0, model);
        n_total++;
        if (sig[3] !== model || cnt[3] !== 16'd100 || done[3] !== 1'b0 || busy[3] !== 1'b1) begin
            $display("FAIL rand_last_beat: sig=%h cnt=%0d done=%b busy=%b, want %h 100 0 1",
                     sig[3], cnt[3], done[3], busy[3], model);
        end else n_pass++;
        @(negedge CK);
        n_total++;
        if (done[3] !== 1'b1 || pass[3] !== 1'b1) begin
            $display("FAIL rand_pass: done=%b pass=%b, want 1 1", done[3], pass[3]);
        end else n_pass++;
        repeat (3) begin
            in_valid = 1'($urandom);
            resp     = 6'($urandom);
            @(negedge CK);
        end
        in_valid = 1'b0;
        n_total++;
        if (sig[3] !== model || cnt[3] !== 16'd100 || done[3] !== 1'b1 || pass[3] !== 1'b1) begin
            $display("FAIL done_hold: sig=%h cnt=%0d done=%b pass=%b, want %h 100 1 1",
                     sig[3], cnt[3], done[3], pass[3], model);
        end else n_pass++;
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        n_total++;
        if (done[3] !== 1'b0 || pass[3] !== 1'b0 || sig[3] !== 16'hACE1 || cnt[3] !== 16'd0
            || busy[3] !== 1'b1) begin
            $display("FAIL restart: done=%b pass=%b sig=%h cnt=%0d busy=%b, want 0 0 ace1 0 1",
                     done[3], pass[3], sig[3], cnt[3], busy[3]);
        end else n_pass++;
        run_session(1'b1, model);
        @(negedge CK);
        n_total++;
        if (done[3] !== 1'b1 || pass[3] !== 1'b0 || sig[3] !== model) begin
            $display("FAIL rand_fail: done=%b pass=%b sig=%h, want 1 0 %h", done[3], pass[3], sig[3], model);
        end else n_pass++;
    endtask

    task automatic test_xmask();
        logic [15:0] exp_sig;
`ifdef S298_MISR_XMASK_EN
        exp_sig = 16'h0001;
`else
        exp_sig = 16'h003F;
`endif
        fresh();
        xmask = 6'h3E;
        drive_beat(6'h3F);
        xmask = 6'h00;
        n_total++;
        if (sig[0] !== exp_sig) begin
            $display("FAIL xmask_sig: sig=%h, want %h", sig[0], exp_sig);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_feedback();
        test_gaps();
        test_abort();
        test_random_session();
        test_xmask();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
